// File: rtl/fence_checker_if.sv
// Point-input stream plus result/status signals of fence_checker.
interface fence_checker_if;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] X;
  logic [9:0] Y;
  logic       valid;
  logic       is_inside;
  logic       busy;

  modport master (output in_valid, X, Y, input in_ready, valid, is_inside, busy);
  modport slave  (input in_valid, X, Y, output in_ready, valid, is_inside, busy);
endinterface

// File: rtl/fence_checker.sv
// Polygon-containment checker: loads a target and N_VERT vertices, then sweeps
// one shared cross-product unit across every edge, one edge per cycle.
module fence_checker #(
  parameter int N_VERT      = 6,
  parameter bit ZERO_INSIDE = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  fence_checker_if.slave  bus
);
  localparam int CW = $clog2(N_VERT);
  localparam logic [CW-1:0] LAST = CW'(N_VERT - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CALC, S_DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic [9:0]    r_tx, r_ty;
  logic [9:0]    r_vx [N_VERT];
  logic [9:0]    r_vy [N_VERT];
  logic [CW-1:0] r_vcnt, r_idx, w_idx_b;
  logic          r_pos, r_neg, r_zero, r_is_inside;
  logic          w_accept, w_in_ready, w_valid, w_busy;
  logic          w_pos_nxt, w_neg_nxt, w_zero_nxt;

  logic signed [10:0] w_x0, w_y0, w_x1, w_y1;
  logic signed [22:0] w_x0e, w_y0e, w_x1e, w_y1e, w_r;

  assign w_idx_b = (r_idx == LAST) ? '0 : r_idx + CW'(1);

  // Shared cross-product unit: (B-A) x (T-A) on zero-extended coordinates
  assign w_x0 = $signed({1'b0, r_vx[w_idx_b]}) - $signed({1'b0, r_vx[r_idx]});
  assign w_y0 = $signed({1'b0, r_vy[w_idx_b]}) - $signed({1'b0, r_vy[r_idx]});
  assign w_x1 = $signed({1'b0, r_tx}) - $signed({1'b0, r_vx[r_idx]});
  assign w_y1 = $signed({1'b0, r_ty}) - $signed({1'b0, r_vy[r_idx]});
  assign w_x0e = {{12{w_x0[10]}}, w_x0};
  assign w_y0e = {{12{w_y0[10]}}, w_y0};
  assign w_x1e = {{12{w_x1[10]}}, w_x1};
  assign w_y1e = {{12{w_y1[10]}}, w_y1};
  assign w_r   = w_x0e * w_y1e - w_y0e * w_x1e;

  assign w_zero_nxt = r_zero | (w_r == '0);
  assign w_neg_nxt  = r_neg  | w_r[22];
  assign w_pos_nxt  = r_pos  | ((w_r != '0) && !w_r[22]);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_valid     = 1'b0;
    w_busy      = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        w_busy     = 1'b0;
        if (bus.in_valid) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        w_in_ready = 1'b1;
        if (bus.in_valid && (r_vcnt == LAST)) w_state_nxt = S_CALC;
      end
      S_CALC: begin
        if (r_idx == LAST) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_valid     = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_accept = bus.in_valid & w_in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tx        <= '0;
      r_ty        <= '0;
      r_vcnt      <= '0;
      r_idx       <= '0;
      r_pos       <= 1'b0;
      r_neg       <= 1'b0;
      r_zero      <= 1'b0;
      r_is_inside <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_tx   <= bus.X;
          r_ty   <= bus.Y;
          r_vcnt <= '0;
          r_pos  <= 1'b0;
          r_neg  <= 1'b0;
          r_zero <= 1'b0;
        end
        S_LOAD: if (w_accept) begin
          r_vx[r_vcnt] <= bus.X;
          r_vy[r_vcnt] <= bus.Y;
          r_vcnt       <= r_vcnt + CW'(1);
          r_idx        <= '0;
        end
        S_CALC: begin
          r_pos  <= w_pos_nxt;
          r_neg  <= w_neg_nxt;
          r_zero <= w_zero_nxt;
          r_idx  <= w_idx_b;
          // Decision uses this edge's flags too, so it lands alongside the last update
          if (r_idx == LAST)
            r_is_inside <= !(w_pos_nxt && w_neg_nxt) && (ZERO_INSIDE || !w_zero_nxt);
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.valid     = w_valid;
  assign bus.busy      = w_busy;
  assign bus.is_inside = r_is_inside;
endmodule
